uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that responds on the CPU data-memory bus (`ce`/`we`/`addr`/`wtData`/`rdData`), sitting beside the data memory in the SoC with its own address window. Stores are queued in a small byte FIFO and serialized on `txd` as 8N1 frames at a programmable baud divisor. Loads return status so firmware can poll before writing.

## Interface
- `BASE_ADDR`, 32'h1000_0000: window base; decode on `addr[31:4] == BASE_ADDR[31:4]`.
- `CLK_DIV`, 434: clocks per bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `ce`  in  1  bus access valid (CPU `memCe`).
- `we`  in  1  1 = store, 0 = load (CPU `memWr`).
- `addr`  in  32  byte address (CPU `memAddr`).
- `wtData`  in  32  store data.
- `rdData`  out  32  load data, combinational.
- `txd`  out  1  serial output, idle high.

## Operation
- Hit = `ce` and window match. Register offsets on `addr[3:2]`:
  - 0x0 TXDATA: store pushes `wtData[7:0]`; load returns 0.
  - 0x4 STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count. Store with `wtData[3]`=1 clears overflow (W1C).
  - 0x8 CTRL: bit0 enable (reset 1). Load returns CTRL.
  - 0xC: reserved; load 0, store ignored.
- `rdData` = selected register when hit and `we`=0; otherwise 32'h0.
- Push to a full FIFO: byte dropped, overflow set. Push on the same edge as a pop from a full FIFO is accepted.
- FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE, or back to START if the FIFO is non-empty and enable=1.
- In IDLE, when the FIFO is non-empty and enable=1, pop the head into the shift register and enter START.
- Clearing enable mid-frame: the current frame completes and no further pops occur.
- Baud counter runs 0..CLK_DIV-1 and resets on every state change. Each bit lasts exactly CLK_DIV cycles.

## Timing
- Reset values: `txd`=1, `rdData`=0 (combinational, no hit), FSM IDLE, FIFO empty, overflow 0, enable 1.
- Reset asserted mid-frame: `txd` goes to 1 immediately (async). The frame is lost.
- Store hit at edge N is visible in STATUS count after edge N.
- With the FSM idle, an empty FIFO and enable=1, a store at edge N causes the pop at edge N+1; `txd` falls at edge N+1.
- Frame length is 10·CLK_DIV cycles, or 11·CLK_DIV with parity.
- Back-to-back frames: the next start bit begins the cycle after the stop bit ends, with no idle gap.
- busy deasserts the cycle after the last stop-bit cycle when the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It sends even parity (XOR of the 8 data bits), and CTRL bit1 selects odd parity when 1 (reset 0).
- Not defined: no PARITY state, CTRL bit1 reads 0 and ignores writes, frame is 8N1.

## Structure
- Shared constants go in `define.v`: UART window base, register offsets (TXDATA/STATUS/CTRL), STATUS bit positions, FSM state encodings.
- One sub-module: `tx_fifo`, a synchronous FIFO parameterized by width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout is the registered head.
  - Simultaneous push+pop is allowed when full or empty-with-push.

## Test plan
All cases use CLK_DIV=4, FIFO_DEPTH=8.
- Reset release, no access -> `txd`=1, STATUS load = 32'h0000_0004, CTRL load = 1.
- Store 0x55 to TXDATA -> `txd` low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), high 4 cycles; busy cleared after 40 cycles.
- Store 9 bytes 0x01..0x09 back-to-back -> first popped immediately, 8 remain with full=1, none dropped, overflow=0. A 10th store -> overflow=1. W1C 0x8 to STATUS -> overflow=0.
- Clear enable during the second frame's data bits -> that frame finishes, `txd` stays high, count holds. Set enable -> transmission resumes with no gap beyond one cycle.
- Assert `rst` mid-frame -> `txd`=1 asynchronously, STATUS = 32'h0000_0004 after release.
- Bus access with `ce`=0 or outside the window -> no push, `rdData`=0. With `UART_TX_PARITY_EN`, 0x07 sends parity bit 1 and each frame is 44 cycles.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: window base,
// register offsets, STATUS/CTRL bit positions and transmit FSM encodings.
package uart_tx_mmio_pkg;

  localparam logic [31:0] UART_BASE_ADDR = 32'h1000_0000;

  // Register select on addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_ODD = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Assemble the STATUS word from its fields
  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_BUSY]  = busy;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_OVF]   = ovf;
    w[STAT_CNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_tx_fifo.sv
// tx_fifo: synchronous FIFO with a registered head output (dout always holds
// the oldest entry while non-empty). Pop on empty is ignored; a push is
// accepted when full only if a pop happens on the same edge.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = dout_q;
  assign count   = count_q;

  // Next pointers, occupancy and head register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head follows the incoming byte when it becomes the only entry,
    // otherwise the entry behind the one being popped.
    if (empty && do_push) begin
      dout_d = din;
    end else if (do_pop) begin
      if (count_q == CW'(1)) dout_d = din;
      else                   dout_d = mem[rd_ptr_d];
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointer, count and head registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the CPU data bus.
// Stores to TXDATA queue bytes in tx_fifo; the FSM serialises them as 8N1
// frames (8E1/8O1 when UART_TX_PARITY_EN is defined) at CLK_DIV clocks/bit.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = UART_BASE_ADDR,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        txd
);

  localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  // Bus decode
  logic       hit, wr_hit, rd_hit;
  logic [1:0] reg_sel;
  assign hit     = ce & (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit  = hit & we;
  assign rd_hit  = hit & ~we;
  assign reg_sel = addr[3:2];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr[1:0], wtData[31:8]};

  // FIFO
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [FCW-1:0] fifo_count;
  assign fifo_push = wr_hit & (reg_sel == REG_TXDATA);

  tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wtData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control / status registers
  logic enable_q, enable_d;
  logic overflow_q, overflow_d;
  logic odd_q, odd_d;

  // Enable and sticky overflow; a drop on the same edge as a clear wins
  always_comb begin
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_hit && reg_sel == REG_CTRL) enable_d = wtData[CTRL_EN];
    if (wr_hit && reg_sel == REG_STATUS && wtData[STAT_OVF]) overflow_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

`ifdef UART_TX_PARITY_EN
  // Parity sense select
  always_comb begin
    odd_d = odd_q;
    if (wr_hit && reg_sel == REG_CTRL) odd_d = wtData[CTRL_ODD];
  end
`else
  assign odd_d = 1'b0;
`endif

  // Register update for CTRL and overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      odd_q      <= odd_d;
    end
  end

  // Transmit FSM state
  tx_state_e   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  data_q;
  logic        txd_q;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  // Pop from IDLE, or chain straight into the next frame at the end of STOP
  assign fifo_pop = ~fifo_empty & enable_q &
                    ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_end));

  // Frame sequencer with registered serial output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      baud_q <= baud_q + 16'd1;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          if (fifo_pop) begin
            state_q <= ST_START;
            data_q  <= fifo_dout;
            txd_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
            txd_q   <= data_q[0];
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              txd_q   <= (^data_q) ^ odd_q;
`else
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= data_q[bit_q + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (fifo_pop) begin
              state_q <= ST_START;
              data_q  <= fifo_dout;
              txd_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd = txd_q;

  // Load data mux: only a read hit drives a non-zero value
  logic [31:0] status_word, ctrl_word;
  assign status_word = pack_status(state_q != ST_IDLE, fifo_full, fifo_empty,
                                   overflow_q, 8'(fifo_count));
  assign ctrl_word   = {30'b0, odd_q, enable_q};

  always_comb begin
    rdData = '0;
    if (rd_hit) begin
      case (reg_sel)
        REG_STATUS: rdData = status_word;
        REG_CTRL:   rdData = ctrl_word;
        default:    rdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8.
// Define UART_TX_PARITY_EN for both bench and RTL to check the parity build.
module tb_uart_tx_mmio;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif
  localparam int FCYC = FLEN * CLK_DIV;

  localparam logic [31:0] A_TXDATA = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CTRL   = 32'h1000_0008;
  localparam logic [31:0] A_RSVD   = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wtData, rdData;
  logic        txd;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_mmio #(
    .BASE_ADDR  (32'h1000_0000),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .wtData (wtData),
    .rdData (rdData),
    .txd    (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle captured on the next rising edge
  task automatic bus_access(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = c; we = w; addr = a; wtData = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
    $display("BUS ce=%0b we=%0b addr=%h data=%h", c, w, a, d);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_access(1'b1, 1'b1, a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdData;
    ce = 1'b0;
    $display("RD addr=%h data=%h", a, d);
  endtask

  // Expected line level for bit slot pos of a frame carrying d (even parity)
  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
`ifdef UART_TX_PARITY_EN
    if (pos == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Check txd for n_cyc cycles starting at the next edge; optionally clear
  // enable with a CTRL store issued after sample ctrl_at.
  task automatic check_frame(input logic [7:0] d, input int n_cyc, input int ctrl_at);
    logic [31:0] st;
    for (int i = 0; i < n_cyc; i++) begin
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0;
      #1;
      check($sformatf("txd_%02h_c%0d", d, i), {31'b0, txd}, {31'b0, exp_bit(d, i / CLK_DIV)});
      if (i == n_cyc - 1) begin
        bus_read(A_STATUS, st);
        check($sformatf("busy_%02h_last", d), st & 32'h1, 32'h1);
      end
      if (i == ctrl_at) begin
        ce = 1'b1; we = 1'b1; addr = A_CTRL; wtData = 32'h0;
        $display("BUS ce=1 we=1 addr=%h data=%h", A_CTRL, 32'h0);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        low_seen;
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wtData = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'h1);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'h0000_0004);
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0000_0001);
    bus_read(A_TXDATA, rd); check("rd_txdata", rd, 32'h0);

    // Single frame 0x55
    bus_write(A_TXDATA, 32'h55);
    bus_read(A_STATUS, rd); check("count_after_store", rd, 32'h0000_0100);
    check_frame(8'h55, FCYC, -1);
    @(posedge clk); #2;
    bus_read(A_STATUS, rd); check("idle_after_frame", rd, 32'h0000_0004);

    // Fill the FIFO, overflow, W1C
    for (int k = 1; k <= 9; k++) bus_write(A_TXDATA, k);
    bus_read(A_STATUS, rd); check("nine_full", rd, 32'h0000_0803);
    bus_write(A_TXDATA, 32'h0A);
    bus_read(A_STATUS, rd); check("overflow_set", rd, 32'h0000_080B);
    bus_write(A_STATUS, 32'h8);
    bus_read(A_STATUS, rd); check("overflow_w1c", rd, 32'h0000_0803);

    // Frame 0x02 follows 0x01 with no gap; enable cleared during its data bits
    repeat (FCYC - 10) @(posedge clk);
    #1;
    check("f1_stop_bit", {31'b0, txd}, 32'h1);
    check_frame(8'h02, FCYC, 12);
    repeat (2) @(posedge clk); #2;
    bus_read(A_STATUS, rd); check("disabled_status", rd, 32'h0000_0700);
    bus_read(A_CTRL, rd);   check("ctrl_cleared", rd, 32'h0);
    low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    check("disabled_txd_high", {31'b0, low_seen}, 32'h0);
    bus_read(A_STATUS, rd); check("disabled_count_hold", rd, 32'h0000_0700);

    // Re-enable: pop on the very next edge
    bus_write(A_CTRL, 32'h1);
    check_frame(8'h03, FCYC, -1);

    // Reset in the middle of frame 0x04 (txd low at that point)
    check_frame(8'h04, 10, -1);
    rst = 1'b0;
    #1;
    check("async_rst_txd", {31'b0, txd}, 32'h1);
    bus_read(A_STATUS, rd); check("status_in_rst", rd, 32'h0000_0004);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, rd); check("status_after_rst", rd, 32'h0000_0004);
    bus_read(A_CTRL, rd);   check("ctrl_after_rst", rd, 32'h0000_0001);

    // Accesses that must not hit
    bus_access(1'b0, 1'b1, A_TXDATA, 32'h33);
    bus_access(1'b1, 1'b1, 32'h1000_0010, 32'h34);
    bus_access(1'b1, 1'b1, 32'h2000_0000, 32'h35);
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk); #2;
    check("no_push_txd", {31'b0, txd}, 32'h1);
    bus_read(A_STATUS, rd); check("no_push_status", rd, 32'h0000_0004);
    addr = A_STATUS; ce = 1'b0; we = 1'b0; #1;
    check("ce0_read", rdData, 32'h0);
    bus_read(32'h1000_0014, rd); check("out_window_read", rd, 32'h0);
    bus_read(A_RSVD, rd);        check("rsvd_read", rd, 32'h0);
    bus_write(A_CTRL, 32'h3);
    bus_read(A_CTRL, rd);
`ifdef UART_TX_PARITY_EN
    check("ctrl_odd_bit", rd, 32'h3);
`else
    check("ctrl_odd_bit", rd, 32'h1);
`endif
    bus_write(A_CTRL, 32'h1);

    // 0x07: odd number of ones (parity bit 1 when enabled)
    bus_write(A_TXDATA, 32'h07);
    check_frame(8'h07, FCYC, -1);
    @(posedge clk); #2;
    bus_read(A_STATUS, rd); check("final_idle", rd, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
